// File: rtl/ring_meter_pkg.sv
// Shared types and constants for the ring-oscillator period meter.
// Imported by the meter top level and its edge detector.
package ring_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } meter_state_t;

  localparam int SYNC_STAGES  = 2;
  localparam int FLUSH_CYCLES = 2;

endpackage

// File: rtl/sync_rise_detect.sv
// Synchronizes an asynchronous input and flags its rising edges.
// Reusable front end for the wrapped measurement projects.
module sync_rise_detect
  import ring_meter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_edge;

endmodule

// File: rtl/ring_period_meter.sv
// Counts ring-oscillator rising edges over a gated window of clocks.
// Result and saturation flag are held until the next accepted start.
module ring_period_meter
  import ring_meter_pkg::*;
#(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              chain_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  meter_state_t      r_state;
  meter_state_t      w_next;
  logic [GATE_W-1:0] r_gate_q;
  logic [GATE_W-1:0] r_win;
  logic [FW-1:0]     r_flush;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              w_rise;
  logic              w_accept;

  sync_rise_detect u_sync (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n),
    .i_d     (chain_in),
    .o_rise  (w_rise)
  );

  assign w_accept = (r_state == IDLE) && start;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (r_flush == FLUSH_LAST)
          w_next = (r_gate_q != '0) ? COUNT : DONE;
      end
      COUNT: begin
        busy = 1'b1;
        if (r_win == GATE_W'(1)) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_gate_q <= '0;
      r_win    <= '0;
      r_flush  <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gate_q <= gate_cycles;
        r_win    <= gate_cycles;
        r_flush  <= '0;
        r_count  <= '0;
        r_ovf    <= 1'b0;
      end
      if (r_state == FLUSH) r_flush <= r_flush + FW'(1);
      if (r_state == COUNT) begin
        r_win <= r_win - GATE_W'(1);
        // saturate rather than wrap so a too-long window is detectable
        if (w_rise) begin
          if (r_count == '1) r_ovf <= 1'b1;
          else r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign count    = r_count;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_ring_period_meter.sv
// Directed bench for ring_period_meter: timing, counts, saturation,
// ignored restarts and asynchronous reset.
module tb_ring_period_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        chain = 1'b0;
  logic        start = 1'b0;
  logic [15:0] gate = '0;
  logic        busy, done, ovf;
  logic [31:0] cnt;
  logic        busy_s, done_s, ovf_s;
  logic [3:0]  cnt_s;

  int n_chk = 0;
  int n_fail = 0;
  int half = 0;
  int ph = 0;
  int c1_s, o1_s;

  ring_period_meter #(.GATE_W(16), .CNT_W(32)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .chain_in(chain),
    .start(start), .gate_cycles(gate), .busy(busy),
    .done(done), .count(cnt), .overflow(ovf)
  );

  ring_period_meter #(.GATE_W(16), .CNT_W(4)) dut_s (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .chain_in(chain),
    .start(start), .gate_cycles(gate), .busy(busy_s),
    .done(done_s), .count(cnt_s), .overflow(ovf_s)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (half != 0) begin
        ph++;
        if (ph >= half) begin
          ph = 0;
          chain = ~chain;
        end
      end
    end
  end

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int g, input int inj, input int rst_at,
                     output int dcyc, output int bcyc,
                     output int ndone);
    int cyc;
    gate = 16'(g);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    dcyc = -1; bcyc = 0; ndone = 0;
    c1_s = cnt_s; o1_s = ovf_s;
    while (cyc <= g + 30) begin
      if (busy) bcyc++;
      if (done) begin
        ndone++;
        if (dcyc < 0) dcyc = cyc;
      end
      start = (cyc == inj);
      if (cyc == inj) gate = 16'd5;
      if (cyc == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_count", cnt, 0);
        check("rst_mid_ovf", ovf, 0);
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  int d, b, nd, nd0;

  initial begin
    half = 1;
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", cnt, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk) rst_n = 1'b1;
    nd0 = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) nd0++;
    end
    check("no_spurious_done", nd0, 0);

    half = 2;
    run(100, -1, -1, d, b, nd);
    check("per_done_cyc", d, 103);
    check("per_busy_cyc", b, 102);
    check("per_count", cnt, 25);
    check("per_ovf", ovf, 0);

    half = 1;
    run(40, -1, -1, d, b, nd);
    check("sat_count_wide", cnt, 20);
    check("sat_count", cnt_s, 15);
    check("sat_ovf", ovf_s, 1);

    run(0, -1, -1, d, b, nd);
    check("sat_clr_count", c1_s, 0);
    check("sat_clr_ovf", o1_s, 0);
    check("zero_done_cyc", d, 3);
    check("zero_busy_cyc", b, 2);
    check("zero_count", cnt, 0);

    half = 0;
    repeat (4) @(posedge clk);
    run(50, 10, -1, d, b, nd);
    check("bsy_done_cyc", d, 53);
    check("bsy_busy_cyc", b, 52);
    check("bsy_ndone", nd, 1);
    check("bsy_count", cnt, 0);

    half = 2;
    run(100, -1, 20, d, b, nd);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run(100, -1, -1, d, b, nd);
    check("post_rst_done_cyc", d, 103);
    check("post_rst_count", cnt, 25);
    check("post_rst_ovf", ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
